// File: rtl/dmux8way16_buffered.sv
// Steers one input word into one of eight 1-entry lane buffers, or into all of them at once.
// Latency: 1 cycle, input edge to lane out_valid. Backpressure: in_ready = target lane(s) free.
// Backpressure: a lane draining this edge counts as free; a broadcast waits until all 8 lanes are free.
module dmux8way16_buffered #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:WIDTH-1] in,
    input  logic [2:0]       sel,
    input  logic             broadcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:WIDTH-1] a,
    output logic [0:WIDTH-1] b,
    output logic [0:WIDTH-1] c,
    output logic [0:WIDTH-1] d,
    output logic [0:WIDTH-1] e,
    output logic [0:WIDTH-1] f,
    output logic [0:WIDTH-1] g,
    output logic [0:WIDTH-1] h,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [15:0]      count
);

    logic [0:WIDTH-1] lane_q [8];
    logic [0:WIDTH-1] lane_d [8];
    logic [7:0]       vld_q;
    logic [7:0]       vld_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;

    logic [7:0] lane_free;
    logic [7:0] lane_sel;
    logic [7:0] lane_wr;
    logic [7:0] lane_drain;
    logic       in_xfer;

    assign lane_free  = ~vld_q | out_ready;
    assign lane_sel   = 8'b0000_0001 << sel;
    assign lane_drain = vld_q & out_ready;

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = broadcast ? (&lane_free) : lane_free[sel];
        end
    end

    assign in_xfer = in_valid & in_ready;
    assign lane_wr = in_xfer ? (broadcast ? 8'hFF : lane_sel) : 8'h00;

    // A write wins over a drain on the same lane: the slot refills in the edge it empties.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < 8; k++) begin
            lane_d[k] = lane_q[k];
            if (lane_wr[k]) begin
                lane_d[k] = in;
                vld_d[k]  = 1'b1;
            end else if (lane_drain[k]) begin
                vld_d[k]  = 1'b0;
            end
        end
        cnt_d = cnt_q + {15'd0, in_xfer};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                lane_q[k] <= '0;
            end
            vld_q <= 8'h00;
            cnt_q <= 16'h0000;
        end else begin
            for (int k = 0; k < 8; k++) begin
                lane_q[k] <= lane_d[k];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign a         = lane_q[0];
    assign b         = lane_q[1];
    assign c         = lane_q[2];
    assign d         = lane_q[3];
    assign e         = lane_q[4];
    assign f         = lane_q[5];
    assign g         = lane_q[6];
    assign h         = lane_q[7];
    assign out_valid = vld_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_dmux8way16_buffered.sv
// Directed and randomized bench for dmux8way16_buffered against a lane-array reference model.
module tb_dmux8way16_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:15] in;
    logic [2:0]  sel;
    logic        broadcast;
    logic        in_valid;
    logic        in_ready;
    logic [0:15] a, b, c, d, e, f, g, h;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_dat [8];
    logic [7:0]  m_vld;
    logic [15:0] m_cnt;
    logic [15:0] lane_o [8];

    always #5 clk = ~clk;

    dmux8way16_buffered #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in(in), .sel(sel), .broadcast(broadcast),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    assign lane_o[0] = a;
    assign lane_o[1] = b;
    assign lane_o[2] = c;
    assign lane_o[3] = d;
    assign lane_o[4] = e;
    assign lane_o[5] = f;
    assign lane_o[6] = g;
    assign lane_o[7] = h;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready(input logic rst, input logic [2:0] s,
                                         input logic bc, input logic [7:0] ordy);
        logic all_free;
        if (rst) return 1'b0;
        all_free = 1'b1;
        for (int k = 0; k < 8; k++)
            if (m_vld[k] && !ordy[k]) all_free = 1'b0;
        return bc ? all_free : (!m_vld[s] || ordy[s]);
    endfunction

    task automatic model_edge(input logic rst, input logic [15:0] din, input logic [2:0] s,
                              input logic bc, input logic iv, input logic [7:0] ordy);
        logic acc;
        if (rst) begin
            for (int k = 0; k < 8; k++) m_dat[k] = 16'h0000;
            m_vld = 8'h00;
            m_cnt = 16'h0000;
            return;
        end
        acc = iv && model_ready(1'b0, s, bc, ordy);
        for (int k = 0; k < 8; k++) begin
            if (acc && (bc || s == 3'(k))) begin
                m_dat[k] = din;
                m_vld[k] = 1'b1;
            end else if (m_vld[k] && ordy[k]) begin
                m_vld[k] = 1'b0;
            end
        end
        if (acc) m_cnt = m_cnt + 16'd1;
    endtask

    task automatic step(input logic rst, input logic [15:0] din, input logic [2:0] s,
                        input logic bc, input logic iv, input logic [7:0] ordy);
        reset = rst; in = din; sel = s; broadcast = bc; in_valid = iv; out_ready = ordy;
        #2;
        check("in_ready", {15'd0, in_ready}, {15'd0, model_ready(rst, s, bc, ordy)});
        @(posedge clk);
        model_edge(rst, din, s, bc, iv, ordy);
        #1;
        check("out_valid", {8'd0, out_valid}, {8'd0, m_vld});
        check("count", count, m_cnt);
        for (int k = 0; k < 8; k++) check($sformatf("lane%0d", k), lane_o[k], m_dat[k]);
    endtask

    initial begin
        logic [2:0] ws;
        for (int k = 0; k < 8; k++) m_dat[k] = 16'h0000;
        m_vld = 8'h00;
        m_cnt = 16'h0000;

        // Reset held two cycles with in_valid asserted
        step(1'b1, 16'h5555, 3'd0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 16'h5555, 3'd0, 1'b0, 1'b1, 8'h00);
        check("rst_valid", {8'd0, out_valid}, 16'h0000);
        check("rst_count", count, 16'h0000);

        // Single route to lane f
        step(1'b0, 16'hBEEF, 3'b101, 1'b0, 1'b1, 8'h00);
        check("route_f", f, 16'hBEEF);
        check("route_valid", {8'd0, out_valid}, 16'h0020);
        check("route_count", count, 16'd1);

        // Backpressure on lane c, then pass-through with same-edge drain
        step(1'b0, 16'h1111, 3'd2, 1'b0, 1'b1, 8'h00);
        step(1'b0, 16'h2222, 3'd2, 1'b0, 1'b1, 8'h00);
        check("bp_c_hold", c, 16'h1111);
        check("bp_count", count, 16'd2);
        step(1'b0, 16'h1234, 3'd2, 1'b0, 1'b1, 8'h04);
        check("pass_c", c, 16'h1234);
        check("pass_count", count, 16'd3);

        // Broadcast blocked by full lane h, then allowed when h drains
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 16'h7777, 3'd7, 1'b0, 1'b1, 8'h00);
        step(1'b0, 16'h00FF, 3'd0, 1'b1, 1'b1, 8'h00);
        check("bc_blocked_valid", {8'd0, out_valid}, 16'h0080);
        step(1'b0, 16'h00FF, 3'd3, 1'b1, 1'b1, 8'h80);
        check("bc_valid", {8'd0, out_valid}, 16'h00FF);
        check("bc_h", h, 16'h00FF);
        check("bc_a", a, 16'h00FF);

        // Concurrent drain of a,b with fill of d
        step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 8'hFC);
        step(1'b0, 16'h0A0A, 3'd3, 1'b0, 1'b1, 8'h03);
        check("conc_valid", {8'd0, out_valid}, 16'h0008);
        check("conc_d", d, 16'h0A0A);
        check("conc_a_keep", a, 16'h00FF);
        check("conc_b_keep", b, 16'h00FF);

        // Randomized traffic, occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 16'($urandom), 3'($urandom),
                 ($urandom_range(0, 5) == 0), 1'($urandom), 8'($urandom));
        end

        // Counter wrap: 65536 accepted words with every lane draining
        step(1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 65536; i++) begin
            ws = 3'($urandom);
            reset = 1'b0; in = 16'(i); sel = ws; broadcast = 1'b0;
            in_valid = 1'b1; out_ready = 8'hFF;
            @(posedge clk);
            model_edge(1'b0, 16'(i), ws, 1'b0, 1'b1, 8'hFF);
            #1;
        end
        check("wrap_count", count, 16'h0000);
        check("wrap_model", count, m_cnt);

        // Reset mid-run with lanes full
        step(1'b0, 16'hAAAA, 3'd0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 16'hBBBB, 3'd1, 1'b0, 1'b1, 8'h00);
        step(1'b0, 16'hCCCC, 3'd2, 1'b0, 1'b1, 8'h00);
        check("pre_rst_count", count, 16'd3);
        step(1'b1, 16'hDDDD, 3'd3, 1'b0, 1'b1, 8'h00);
        check("mid_rst_valid", {8'd0, out_valid}, 16'h0000);
        check("mid_rst_count", count, 16'h0000);
        step(1'b0, 16'hEEEE, 3'd4, 1'b0, 1'b1, 8'h00);
        check("post_rst_count", count, 16'd1);
        check("post_rst_e", e, 16'hEEEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
